l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-port arbiter that shares the single L2 cache port between the instruction-cache miss path and the data-cache miss/writeback path of the LC-3b pipelined processor. It sits between `icache_control`/`dcache_control` and the L2 cache. It grants one requester at a time, holds the grant until L2 responds, and routes the response back to the owner. Contention is resolved round-robin, so neither pipeline stage starves.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte address width.
- `LINE_WIDTH`, 128: cache line width in bits.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_read`  in  1  icache line-fill request; held high until `i_resp`.
- `i_addr`  in  ADDR_WIDTH  icache miss address.
- `i_rdata`  out  LINE_WIDTH  fill data to icache.
- `i_resp`  out  1  one-cycle completion pulse to icache.
- `d_read`  in  1  dcache line-fill request; held until `d_resp`.
- `d_write`  in  1  dcache writeback request; held until `d_resp`.
- `d_addr`  in  ADDR_WIDTH  dcache address.
- `d_wdata`  in  LINE_WIDTH  writeback line.
- `d_rdata`  out  LINE_WIDTH  fill data to dcache.
- `d_resp`  out  1  one-cycle completion pulse to dcache.
- `l2_read`  out  1  read request to L2.
- `l2_write`  out  1  write request to L2.
- `l2_addr`  out  ADDR_WIDTH  L2 address.
- `l2_wdata`  out  LINE_WIDTH  L2 write line.
- `l2_rdata`  in  LINE_WIDTH  L2 read line.
- `l2_resp`  in  1  L2 completion, valid for one or more cycles; the first high cycle completes the transaction.

## Operation
- State register with three states: IDLE, SERVE_I, SERVE_D. Fairness register `last_d` is 1 when the most recent grant went to the dcache.
- Reset: state = IDLE, `last_d` = 0. All outputs are 0: `l2_read`, `l2_write`, `i_resp`, `d_resp`, `l2_addr`, `l2_wdata`.
- IDLE: no L2 request driven, and `l2_resp` is ignored.
  - Only `i_read` pending -> SERVE_I.
  - Only the dcache pending (`d_read|d_write`) -> SERVE_D.
  - Both pending -> SERVE_I if `last_d`=1, else SERVE_D.
  - Nothing pending -> stay in IDLE.
  - `last_d` updates on every grant.
- SERVE_I: `l2_read`=1, `l2_write`=0, `l2_addr`=`i_addr`. On `l2_resp`, `i_resp`=1 in the same cycle, then next state = IDLE.
- SERVE_D: `l2_addr`=`d_addr`, `l2_wdata`=`d_wdata`.
  - If `d_write`=1: `l2_write`=1 and `l2_read`=0. Write wins if `d_read` and `d_write` are both high.
  - Otherwise `l2_read`=`d_read`.
  - On `l2_resp`, `d_resp`=1 in the same cycle, then next state = IDLE.
- Read data: `i_rdata` and `d_rdata` both equal `l2_rdata` at all times. Only the resp pulse is steered.
- The grant is never pre-empted. A request arriving mid-transaction waits in IDLE arbitration.
- Protocol violation: if the owner drops its request before `l2_resp`, the arbiter still holds the grant, keeps driving the latched command type, and waits for `l2_resp`. It then pulses resp to the owner and returns to IDLE.
- `l2_addr` and `l2_wdata` are 0 in IDLE.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N drives `l2_read`/`l2_write` from cycle N+1.
- Resp is combinational from `l2_resp` in SERVE states, so it appears in the same cycle.
- After any completion, exactly one IDLE cycle occurs before the next grant. This lets the finished cache drop its request, since `icache_control` deasserts the request in SET_STATUS_MISS.
- Minimum transaction cost: L2 latency + 1 cycle. Back-to-back alternating service under contention: grants go D, I, D, I…
- Reset asserted mid-transaction: the next edge forces IDLE with all outputs 0. Any late `l2_resp` is ignored.
- `l2_resp` held high across the return to IDLE generates no second resp.

## Test plan
- Reset: hold `reset` for 2 cycles with `i_read`=1 -> all outputs 0 and state IDLE. Release reset -> `l2_read`=1 with `l2_addr`=`i_addr` 1 cycle later.
- Lone icache miss, `i_addr`=0x1230, L2 resp after 5 cycles, `l2_rdata`=0xA5…A5 -> `i_resp` pulses 1 cycle with `i_rdata`=0xA5…A5. `d_resp` stays 0, and `l2_read` drops the cycle after.
- Simultaneous first contention: `i_read`=1 and `d_read`=1 after reset -> dcache served first (`last_d`=0), one IDLE cycle, then icache. Both requests held continuously -> grant order D, I, D, I.
- Dcache writeback: `d_write`=1, `d_read`=1, `d_addr`=0x4000, `d_wdata`=0x1 -> `l2_write`=1, `l2_read`=0, `l2_wdata`=0x1. `d_resp` pulses on `l2_resp`.
- Mid-transaction arrival: `i_read` rises while SERVE_D waits on L2 -> `l2_addr` stays at `d_addr`. `i_read` is granted 1 IDLE cycle after `d_resp`.
- Reset during SERVE_I with `l2_resp` arriving 1 cycle after reset -> no `i_resp` pulse, and the arbiter stays IDLE.

Source files
------------

// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single L2 cache port between the icache miss path and the dcache
// miss/writeback path. One requester owns the L2 port at a time. The owner
// keeps the grant until L2 answers. The L2 completion is then steered back to
// the owner as a one-cycle resp pulse. Contention is settled round-robin
// through last_d, so neither cache can starve the other.
//
// Ports
//   clk, reset          : system clock; synchronous active-high reset
//   i_read, i_addr      : icache line-fill request and miss address
//   i_rdata, i_resp     : fill data and completion pulse to the icache
//   d_read, d_write     : dcache fill / writeback requests
//   d_addr, d_wdata     : dcache address and writeback line
//   d_rdata, d_resp     : fill data and completion pulse to the dcache
//   l2_read, l2_write   : command to L2
//   l2_addr, l2_wdata   : address and write line to L2
//   l2_rdata, l2_resp   : read line and completion from L2
// ---------------------------------------------------------------------------
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  // The dcache command type is captured at grant time. If the dcache drops
  // its request before L2 answers, L2 still sees a stable command.
  logic   write_q, write_d;

  logic   i_pend;
  logic   d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // Fill data is broadcast to both caches. Only the resp pulse tells a cache
  // that the data is meant for it.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // State, fairness and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      write_q  <= write_d;
    end
  end

  // Next-state and arbitration. Grants are only issued from IDLE. Every
  // completion therefore passes through one IDLE cycle. This gives the
  // finished cache time to drop its request before it could be re-granted.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    write_d  = write_q;

    unique case (state_q)
      IDLE: begin
        if (i_pend && (!d_pend || last_d_q)) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
        end else if (d_pend) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          write_d  = d_write;
        end
      end
      SERVE_I: begin
        if (l2_resp) state_d = IDLE;
      end
      SERVE_D: begin
        if (l2_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. L2 outputs depend only on the owner. Resp is passed
  // straight through from l2_resp so the owner sees it in the same cycle.
  // In IDLE, l2_resp is ignored.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;

    unique case (state_q)
      SERVE_I: begin
        l2_read = 1'b1;
        l2_addr = i_addr;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        l2_write = write_q;
        l2_read  = ~write_q;
        d_resp   = l2_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter
//
// Directed bench for l2_arbiter. The bench drives the caches and plays the L2
// by hand. Every expected value below is worked out from the arbiter's
// intended behaviour.
// ---------------------------------------------------------------------------
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  int checks   = 0;
  int failures = 0;

  localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Watchdog so that a broken run still ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [LW-1:0] got,
                             input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Moves to just after the next rising edge, away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives the request/response controls, then lets the combinational
  // outputs settle before anything is checked.
  task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                               input logic resp);
    i_read  = ir;
    d_read  = dr;
    d_write = dw;
    l2_resp = resp;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    i_addr   = 16'h1230;
    d_addr   = 16'h2000;
    d_wdata  = '0;
    l2_rdata = LINE_A5;
    applyStimulus(1'b1, 1'b0, 0, 1'b0);

    // Reset held for two cycles with an icache request pending.
    tick();
    tick();
    checkOutput("rst_l2_read",  128'(l2_read),  128'(0));
    checkOutput("rst_l2_write", 128'(l2_write), 128'(0));
    checkOutput("rst_l2_addr",  128'(l2_addr),  128'(0));
    checkOutput("rst_l2_wdata", l2_wdata,       128'(0));
    checkOutput("rst_i_resp",   128'(i_resp),   128'(0));
    checkOutput("rst_d_resp",   128'(d_resp),   128'(0));

    // Release reset. Arbitration happens on the next edge.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rel_idle_read", 128'(l2_read), 128'(0));
    tick();
    checkOutput("grant_i_read", 128'(l2_read), 128'(1));
    checkOutput("grant_i_addr", 128'(l2_addr), 128'(16'h1230));

    // Lone icache miss. L2 answers five cycles after the grant.
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("wait_i_resp", 128'(i_resp), 128'(0));
    end
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lone_i_resp",  128'(i_resp),  128'(1));
    checkOutput("lone_i_rdata", i_rdata,       LINE_A5);
    checkOutput("lone_d_rdata", d_rdata,       LINE_A5);
    checkOutput("lone_d_resp",  128'(d_resp),  128'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lone_after_read", 128'(l2_read), 128'(0));
    checkOutput("lone_after_resp", 128'(i_resp),  128'(0));

    // Contention with both requests held. The last grant went to the icache,
    // so the dcache wins first. Grants then alternate D, I, D, I.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      logic is_d;
      is_d = (k % 2 == 0);
      checkOutput("rr_addr", 128'(l2_addr),
                  is_d ? 128'(16'h2000) : 128'(16'h1230));
      checkOutput("rr_read", 128'(l2_read), 128'(1));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("rr_d_resp", 128'(d_resp), 128'(is_d));
      checkOutput("rr_i_resp", 128'(i_resp), 128'(!is_d));
      tick();
      // On the first round, l2_resp stays high into IDLE. It must not
      // produce a second pulse.
      applyStimulus(1'b1, 1'b1, 1'b0, (k == 0));
      checkOutput("rr_idle_read",   128'(l2_read), 128'(0));
      checkOutput("rr_idle_d_resp", 128'(d_resp),  128'(0));
      checkOutput("rr_idle_i_resp", 128'(i_resp),  128'(0));
      if (k == 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("rr_done_idle", 128'(l2_read), 128'(0));

    // Dcache writeback with both command bits set. Write takes priority.
    d_addr  = 16'h4000;
    d_wdata = 128'h1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("wb_write", 128'(l2_write), 128'(1));
    checkOutput("wb_read",  128'(l2_read),  128'(0));
    checkOutput("wb_wdata", l2_wdata,       128'h1);
    checkOutput("wb_addr",  128'(l2_addr),  128'(16'h4000));

    // An icache request arriving mid-transaction must not disturb the owner.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("mid_addr",   128'(l2_addr), 128'(16'h4000));
    checkOutput("mid_i_resp", 128'(i_resp),  128'(0));

    // The dcache drops its request early. The latched write must stay on.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_write", 128'(l2_write), 128'(1));
    checkOutput("drop_read",  128'(l2_read),  128'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wb_d_resp", 128'(d_resp), 128'(1));
    checkOutput("wb_i_resp", 128'(i_resp), 128'(0));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wb_idle_addr", 128'(l2_addr), 128'(0));
    checkOutput("wb_idle_read", 128'(l2_read), 128'(0));
    tick();
    checkOutput("late_i_read", 128'(l2_read), 128'(1));
    checkOutput("late_i_addr", 128'(l2_addr), 128'(16'h1230));

    // Reset during SERVE_I. An L2 resp one cycle later must be ignored.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rstmid_i_resp",  128'(i_resp),  128'(0));
    checkOutput("rstmid_l2_read", 128'(l2_read), 128'(0));
    tick();
    checkOutput("rstmid_stay_idle", 128'(l2_read), 128'(0));
    checkOutput("rstmid_no_resp",   128'(i_resp),  128'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
